glitch_sequencer: RTL

Parametrised clock-glitch sequencer for the fault-injection fabric. On an armed trigger it waits a programmable delay, then opens N glitch windows of programmable width separated by programmable gaps. During each window the emitted clock is the base clock XORed with the phase-shifted PLL clock. It sits between the PLL phase-shift output and the target clock pin and supersedes the free-running XOR glitcher.

---
 rtl/glitch_pkg.sv | 8 +
 rtl/glitch_trig_sync.sv | 21 ++
 rtl/glitch_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/glitch_pkg.sv
// glitch_pkg: shared state encoding and default sizes for the glitch sequencer
package glitch_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, GLITCH, GAP} state_t;
  localparam int DELAY_W_DEF = 16;
  localparam int WIDTH_W_DEF = 8;
  localparam int REP_W_DEF = 4;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/glitch_trig_sync.sv
// glitch_trig_sync: two-flop synchroniser plus registered rising-edge pulse for the async trigger
module glitch_trig_sync
  import glitch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic trig_i,
  output logic pulse
);
  logic [SYNC_STAGES:0] sync;
  // shift the trigger through the synchroniser; the last stage only serves the edge compare
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= '0;
      pulse <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-1:0], trig_i};
      pulse <= sync[SYNC_STAGES-1] & ~sync[SYNC_STAGES];
    end
  end
endmodule

// File: rtl/glitch_sequencer.sv
// glitch_sequencer: delay/width/gap/repeat clock-glitch burst generator; GLITCH_SEQ_STATS_EN adds burst_cnt/abort_cnt
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int DELAY_W = DELAY_W_DEF,
  parameter int WIDTH_W = WIDTH_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               phase_clk,
  input  logic               trig_i,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic [DELAY_W-1:0] delay_cfg,
  input  logic [WIDTH_W-1:0] width_cfg,
  input  logic [WIDTH_W-1:0] gap_cfg,
  input  logic [REP_W-1:0]   rep_cfg,
  output logic               glitch_en,
  output logic               glitch_clk,
  output logic               armed,
  output logic               busy,
  output logic               done
`ifdef GLITCH_SEQ_STATS_EN
  ,
  output logic [15:0]        burst_cnt,
  output logic [7:0]         abort_cnt
`endif
);
  state_t state, nxt;
  logic [DELAY_W-1:0] delay_sh, dly_cnt, dly_nxt;
  logic [WIDTH_W-1:0] width_sh, gap_sh, win_cnt, win_nxt, width_eff, gap_eff;
  logic [REP_W-1:0] rep_sh, rep_cnt, rep_nxt, rep_eff;
  logic trig_edge, done_nxt;

  glitch_trig_sync u_sync (
    .clk(clk),
    .reset(reset),
    .trig_i(trig_i),
    .pulse(trig_edge)
  );

  assign width_eff = (width_sh == '0) ? WIDTH_W'(1) : width_sh;
  assign gap_eff = (gap_sh == '0) ? WIDTH_W'(1) : gap_sh;
  assign rep_eff = (rep_sh == '0) ? REP_W'(1) : rep_sh;
  assign armed = (state == ARMED);
  assign busy = (state == DELAY) || (state == GLITCH) || (state == GAP);
  assign glitch_clk = clk ^ (phase_clk & glitch_en);

  // next-state and counter updates; one window counter serves both width and gap phases
  always_comb begin
    nxt = state;
    dly_nxt = dly_cnt;
    win_nxt = win_cnt;
    rep_nxt = rep_cnt;
    done_nxt = 1'b0;
    case (state)
      IDLE: nxt = arm_i ? ARMED : IDLE;
      ARMED: begin
        if (trig_edge) begin
          nxt = (delay_sh == '0) ? GLITCH : DELAY;
          dly_nxt = delay_sh;
          win_nxt = width_eff;
          rep_nxt = rep_eff;
        end
      end
      DELAY: begin
        dly_nxt = dly_cnt - DELAY_W'(1);
        nxt = (dly_cnt == DELAY_W'(1)) ? GLITCH : DELAY;
      end
      GLITCH: begin
        if (win_cnt == WIDTH_W'(1)) begin
          nxt = GAP;
          win_nxt = gap_eff;
          rep_nxt = rep_cnt - REP_W'(1);
        end else begin
          win_nxt = win_cnt - WIDTH_W'(1);
        end
      end
      GAP: begin
        if (win_cnt == WIDTH_W'(1)) begin
          nxt = (rep_cnt != '0) ? GLITCH : IDLE;
          win_nxt = width_eff;
          done_nxt = (rep_cnt == '0);
        end else begin
          win_nxt = win_cnt - WIDTH_W'(1);
        end
      end
      default: nxt = IDLE;
    endcase
    if (abort_i) begin
      nxt = IDLE;
      done_nxt = 1'b0;
    end
  end

  // state, counters, registered outputs and config shadows (captured only on an accepted arm)
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      dly_cnt <= '0;
      win_cnt <= '0;
      rep_cnt <= '0;
      delay_sh <= '0;
      width_sh <= '0;
      gap_sh <= '0;
      rep_sh <= '0;
      glitch_en <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      dly_cnt <= dly_nxt;
      win_cnt <= win_nxt;
      rep_cnt <= rep_nxt;
      glitch_en <= (nxt == GLITCH);
      done <= done_nxt;
      if (state == IDLE && arm_i && !abort_i) begin
        delay_sh <= delay_cfg;
        width_sh <= width_cfg;
        gap_sh <= gap_cfg;
        rep_sh <= rep_cfg;
      end
    end
  end

`ifdef GLITCH_SEQ_STATS_EN
  // saturating completed-burst and abort counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      burst_cnt <= '0;
      abort_cnt <= '0;
    end else begin
      if (done_nxt && burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'd1;
      if (abort_i && state != IDLE && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
    end
  end
`endif
endmodule
